uart_receiver: RTL and testbench
================================

# uart_receiver

Standalone 16x-oversampling UART receive path. It turns the serial `rxd` line into bytes, checks parity and framing on each frame, and queues results in a small FIFO for a host that reads with the active-low `rdn` strobe. It is the receive-side counterpart to the team's UART transmit logic and runs on the same `clk16x` bit-rate clock.

## Interface
- `DEPTH`, default 4: FIFO entries; must be a power of 2 and at least 2.
- `clk16x`  in  1  clock at 16x the baud rate; all logic on its rising edge.
- `clrn`  in  1  asynchronous active-low reset.
- `rxd`  in  1  serial input; idles high; asynchronous to `clk16x`.
- `rdn`  in  1  active-low read strobe; pops the FIFO head.
- `d_out`  out  8  data byte of the FIFO head (first-word fall-through).
- `r_ready`  out  1  FIFO not empty.
- `parity_error`  out  1  parity error flag of the head entry.
- `frame_error`  out  1  stop-bit error flag of the head entry.
- `overrun`  out  1  sticky; a completed frame was dropped because the FIFO was full.

## Operation
- `rxd` passes through a 2-flop synchronizer; call its output `rxd_s`. All decisions use `rxd_s`.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 odd-parity bit (configurable), 1 stop bit (1).
- Each bit is sampled at ticks 7, 8 and 9 of its 16-tick cell. The bit value is the 2-of-3 majority, decided on the tick-9 edge.
- FSM states and transitions:
  - IDLE: when `rxd_s` = 0, clear the tick counter (tick 0 = T0) and go to START.
  - START: if the majority vote is 1 (glitch), go to IDLE; otherwise go to DATA.
  - DATA: shift in 8 bits, then go to PARITY (or to STOP when parity is compiled out).
  - PARITY: record `parity_error` = 1 unless data plus the parity bit contain an odd number of 1s.
  - STOP: on the vote, push {frame_error = ~stop, parity_error, data}. If stop = 1, go to IDLE. If stop = 0, go to HUNT.
  - HUNT: wait until `rxd_s` = 1, then go to IDLE. A held-low break line therefore yields exactly one entry.
- Back-to-back frames: IDLE is re-entered right after the stop decision (mid-stop), so a start bit that immediately follows is accepted.
- FIFO push:
  - If the FIFO is full at the push edge, the new entry is discarded and `overrun` is set.
  - `overrun` clears on the next successful pop.
  - If a pop and a set occur on the same edge, the set wins.
- FIFO pop: occurs on an edge where `rdn` = 0 and `r_ready` = 1. A pop while empty is ignored.
- Push and pop on the same edge when full: both happen, nothing is dropped, and the count is unchanged.
- Pointers are log2(DEPTH) bits wide and wrap naturally. Full/empty are tracked with a count of width log2(DEPTH)+1.
- Reset mid-frame: the FSM goes to IDLE, the FIFO is emptied and all flags clear. Any partial frame is lost.

## Timing
- Reset values: `d_out` = 8'h00, `r_ready` = 0, `parity_error` = 0, `frame_error` = 0, `overrun` = 0, FSM = IDLE, synchronizer flops = 1.
- Latency from a falling edge on `rxd` to T0: 2 to 3 clocks (synchronizer).
- Data bit n is decided at T0 + 16(n+1) + 9.
- Push edge: T0 + 169 with parity, T0 + 153 without.
- `r_ready`, `d_out` and the head flags become valid right after the push edge.
- After a pop edge, the next entry (or the empty state) is visible immediately.
- A host that drives `rdn <= !r_ready` on each clock pops each entry exactly once, with no double pop.

## Configuration
- `UART_RX_PARITY_EN` defined: 11-bit frame, PARITY state present, odd parity checked.
- `UART_RX_PARITY_EN` undefined: 10-bit frame, no PARITY state, `parity_error` tied to 0, push at T0 + 153.

## Structure
- Shared package `uart_pkg` holds:
  - the FSM state enum (IDLE, START, DATA, PARITY, STOP, HUNT);
  - `DATA_BITS` = 8 and `OVERSAMPLE` = 16;
  - the sample tick constants 7/8/9;
  - the 10-bit FIFO entry struct {frame_err, parity_err, data}.
- Sub-module `uart_rx_fifo`, parameterised by DEPTH: handles push, pop, count, full/empty and first-word fall-through output.

## Test plan
- Reset: `clrn` = 0 mid-frame → all outputs at reset values. After release, an idle high line produces no entry.
- Frame 8'hE1 with parity bit 1 → `r_ready` rises at T0 + 169, `d_out` = E1, both errors 0. A `rdn` pulse returns `r_ready` to 0.
- Frame 8'h55 with parity bit 0 (wrong), sent back-to-back after a good 8'h55 → entries 55/pe=0, then 55/pe=1, read in order.
- Stop bit 0 followed by `rxd` held low for 40 bit times → exactly one entry: 00, `frame_error` = 1. The next valid frame after `rxd` returns high is received correctly.
- `rxd` low for only 4 ticks → START rejects it; no entry and no state change.
- DEPTH+1 frames (01..05) with no reads → `overrun` = 1 and entries 01..04 kept. The first pop gives 01 and clears `overrun`.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the 16x-oversampling UART receive path:
// FSM state encoding, frame constants, vote tick positions and the
// FIFO entry layout.
package uart_pkg;

    localparam int DATA_BITS  = 8;
    localparam int OVERSAMPLE = 16;

    // Tick positions inside a 16-tick bit cell used for the 2-of-3 vote.
    localparam int TICK_S0 = 7;
    localparam int TICK_S1 = 8;
    localparam int TICK_S2 = 9;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        HUNT   = 3'd5
    } uart_state_e;

    typedef struct packed {
        logic                 frame_err;
        logic                 parity_err;
        logic [DATA_BITS-1:0] data;
    } uart_entry_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive FIFO with first-word fall-through head output.
// A push into a full FIFO is dropped and raises a sticky overrun flag,
// unless a pop happens on the same edge, in which case both proceed.
// The head output reads as all zeros while the FIFO is empty.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       push_i,
    input  logic [9:0] entry_i,
    input  logic       rd_n_i,
    output logic [9:0] head_o,
    output logic       ready_o,
    output logic       overrun_o
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

    uart_entry_t   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          overrun_q, overrun_d;
    logic          empty, full, do_pop, do_push, drop;

    // Qualify push/pop against the occupancy and compute next pointers/flags.
    always_comb begin
        empty     = (count_q == '0);
        full      = (count_q == FULL_CNT);
        do_pop    = !rd_n_i && !empty;
        do_push   = push_i && (!full || do_pop);
        drop      = push_i && !do_push;
        wr_ptr_d  = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d  = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d   = count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        // A drop on the same edge as a pop keeps the flag set.
        overrun_d = drop ? 1'b1 : (do_pop ? 1'b0 : overrun_q);
    end

    // Storage array; contents need no reset because the head is gated when empty.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= entry_i;
        end
    end

    // Pointer, occupancy and overrun registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    // First-word fall-through head and status outputs.
    always_comb begin
        ready_o   = !empty;
        head_o    = empty ? 10'h000 : mem_q[rd_ptr_q];
        overrun_o = overrun_q;
    end

endmodule

// File: rtl/uart_receiver.sv
// 16x-oversampling UART receiver: 2-flop input synchronizer, frame FSM
// with 2-of-3 majority sampling, and a small result FIFO.
// Optional feature macro: UART_RX_PARITY_EN (adds an odd-parity bit).
//
// Host handshake: r_ready high means d_out/parity_error/frame_error hold
// a valid head entry. The entry is consumed on a rising clk16x edge where
// rdn = 0 and r_ready = 1; rdn = 0 while r_ready = 0 has no effect. The
// next entry (or empty state) is visible right after the pop edge.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk16x,
    input  logic       clrn,
    input  logic       rxd,
    input  logic       rdn,
    output logic [7:0] d_out,
    output logic       r_ready,
    output logic       parity_error,
    output logic       frame_error,
    output logic       overrun,
    output logic [2:0] fsm_state
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);

    logic                 rxd_meta_q, rxd_sync_q, rxd_s;
    uart_state_e          state_q, state_d;
    logic [TW-1:0]        tick_q, tick_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 s0_q, s0_d, s1_q, s1_d;
`ifdef UART_RX_PARITY_EN
    logic                 perr_q, perr_d;
`endif
    logic                 decide, vote, push;
    logic [9:0]           entry;
    uart_entry_t          head;

    // Two-flop synchronizer for the asynchronous serial input; idles high.
    always_ff @(posedge clk16x or negedge clrn) begin
        if (!clrn) begin
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
        end else begin
            rxd_meta_q <= rxd;
            rxd_sync_q <= rxd_meta_q;
        end
    end

    assign rxd_s = rxd_sync_q;

    // tick_q counts edges since T0, so the edge for tick k is the one
    // where tick_q still holds k-1. The vote closes on the tick-9 edge.
    assign decide = (tick_q == TW'(TICK_S2 - 1)) && (state_q != IDLE) && (state_q != HUNT);
    assign vote   = majority3(s0_q, s1_q, rxd_s);

    // FSM state and receive datapath registers.
    always_ff @(posedge clk16x or negedge clrn) begin
        if (!clrn) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            s0_q    <= 1'b1;
            s1_q    <= 1'b1;
`ifdef UART_RX_PARITY_EN
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            s0_q    <= s0_d;
            s1_q    <= s1_d;
`ifdef UART_RX_PARITY_EN
            perr_q  <= perr_d;
`endif
        end
    end

    // Next-state logic: frame sequencing, bit shifting and parity check.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        s0_d    = (tick_q == TW'(TICK_S0 - 1)) ? rxd_s : s0_q;
        s1_d    = (tick_q == TW'(TICK_S1 - 1)) ? rxd_s : s1_q;
`ifdef UART_RX_PARITY_EN
        perr_d  = perr_q;
`endif
        case (state_q)
            IDLE: begin
                tick_d = '0;
                if (!rxd_s) state_d = START;
            end
            START: begin
                if (decide) begin
                    bit_d   = '0;
                    state_d = vote ? IDLE : DATA;
                end
            end
            DATA: begin
                if (decide) begin
                    shift_d = {vote, shift_q[DATA_BITS-1:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == BW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (decide) begin
                    // Odd parity: data plus parity bit must hold an odd count of ones.
                    perr_d  = ~(^{shift_q, vote});
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                // Return to IDLE mid-stop so an immediately following start bit is caught.
                if (decide) state_d = vote ? IDLE : HUNT;
            end
            HUNT: begin
                if (rxd_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic: FIFO push on the stop vote and debug state view.
    always_comb begin
        push      = (state_q == STOP) && decide;
`ifdef UART_RX_PARITY_EN
        entry     = {~vote, perr_q, shift_q};
`else
        entry     = {~vote, 1'b0, shift_q};
`endif
        fsm_state = state_q;
    end

    uart_rx_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk_i    (clk16x),
        .rst_ni   (clrn),
        .push_i   (push),
        .entry_i  (entry),
        .rd_n_i   (rdn),
        .head_o   (head),
        .ready_o  (r_ready),
        .overrun_o(overrun)
    );

    assign d_out        = head.data;
    assign parity_error = head.parity_err;
    assign frame_error  = head.frame_err;

endmodule

// File: tb/tb_uart_receiver.sv
// Testbench for uart_receiver: drives serial frames bit-cell by bit-cell
// and compares the host-visible FIFO against a queue-based frame model.
module tb_uart_receiver;
    import uart_pkg::*;

    localparam int DEPTH = 4;
`ifdef UART_RX_PARITY_EN
    localparam int PUSH_LAT = 169;
`else
    localparam int PUSH_LAT = 153;
`endif

    logic       clk16x;
    logic       clrn;
    logic       rxd;
    logic       rdn;
    logic [7:0] d_out;
    logic       r_ready;
    logic       parity_error;
    logic       frame_error;
    logic       overrun;
    logic [2:0] fsm_state;

    int         n_cmp  = 0;
    int         n_fail = 0;

    logic [9:0] exp_q[$];
    logic       exp_overrun;
    logic [9:0] got;

    uart_receiver #(.DEPTH(DEPTH)) dut (
        .clk16x      (clk16x),
        .clrn        (clrn),
        .rxd         (rxd),
        .rdn         (rdn),
        .d_out       (d_out),
        .r_ready     (r_ready),
        .parity_error(parity_error),
        .frame_error (frame_error),
        .overrun     (overrun),
        .fsm_state   (fsm_state)
    );

    // ---------------- clock ----------------
    initial clk16x = 1'b0;
    always #5 clk16x = ~clk16x;

    // ---------------- reference model ----------------
    function automatic logic [9:0] frame_entry(input logic [7:0] d, input logic pbit, input logic stop);
        int   ones;
        logic pe;
        ones = $countones(d) + int'(pbit);
`ifdef UART_RX_PARITY_EN
        pe = ((ones % 2) == 0);
`else
        pe = 1'b0;
`endif
        return {~stop, pe, d};
    endfunction

    function automatic logic good_pbit(input logic [7:0] d);
        return ~(^d);
    endfunction

    task automatic model_push(input logic [9:0] e);
        if (exp_q.size() < DEPTH) exp_q.push_back(e);
        else exp_overrun = 1'b1;
    endtask

    task automatic model_pop();
        if (exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            exp_overrun = 1'b0;
        end
    endtask

    // ---------------- drivers (callers stay at posedge + 1) ----------------
    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk16x);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rxd = b;
        wait_clks(16);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(pbit);
`endif
        send_bit(stop);
        rxd = 1'b1;
    endtask

    task automatic pulse_rdn();
        rdn = 1'b0;
        wait_clks(1);
        rdn = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [7:0] d;
        clrn = 1'b0;
        rxd  = 1'b1;
        rdn  = 1'b1;
        exp_q.delete();
        exp_overrun = 1'b0;
        wait_clks(3);
        got = {frame_error, parity_error, d_out};
        n_cmp++; if (got !== 10'h000) begin n_fail++; $display("FAIL reset_head got %h exp %h", got, 10'h000); end
        n_cmp++; if (r_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b exp 0", r_ready); end
        n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got %b exp 0", overrun); end
        n_cmp++; if (fsm_state !== IDLE) begin n_fail++; $display("FAIL reset_state got %0d exp %0d", fsm_state, IDLE); end
        clrn = 1'b1;
        wait_clks(4);
        d = 8'($urandom_range(0, 255));
        send_frame(d, good_pbit(d), 1'b1);
        model_push(frame_entry(d, good_pbit(d), 1'b1));
        wait_clks(2);
        n_cmp++; if (r_ready !== 1'b1) begin n_fail++; $display("FAIL pre_reset_ready got %b exp 1", r_ready); end
        // start another frame and cut it off with reset
        rxd = 1'b0;
        wait_clks(60);
        n_cmp++; if (fsm_state === IDLE) begin n_fail++; $display("FAIL midframe_state got %0d exp not %0d", fsm_state, IDLE); end
        clrn = 1'b0;
        #1;
        exp_q.delete();
        exp_overrun = 1'b0;
        got = {frame_error, parity_error, d_out};
        n_cmp++; if (r_ready !== 1'b0) begin n_fail++; $display("FAIL midreset_ready got %b exp 0", r_ready); end
        n_cmp++; if (got !== 10'h000) begin n_fail++; $display("FAIL midreset_head got %h exp %h", got, 10'h000); end
        n_cmp++; if (fsm_state !== IDLE) begin n_fail++; $display("FAIL midreset_state got %0d exp %0d", fsm_state, IDLE); end
        rxd = 1'b1;
        wait_clks(3);
        clrn = 1'b1;
        wait_clks(400);
        n_cmp++; if (r_ready !== 1'b0) begin n_fail++; $display("FAIL idle_no_entry got %b exp 0", r_ready); end
        n_cmp++; if (fsm_state !== IDLE) begin n_fail++; $display("FAIL idle_state got %0d exp %0d", fsm_state, IDLE); end
    endtask

    task automatic test_first_frame();
        int cnt;
        bit seen;
        cnt  = 0;
        seen = 1'b0;
        fork
            send_frame(8'hE1, 1'b1, 1'b1);
            begin
                while (!seen && cnt < 400) begin
                    @(posedge clk16x);
                    #1;
                    cnt++;
                    if (r_ready === 1'b1) seen = 1'b1;
                end
            end
        join
        model_push(frame_entry(8'hE1, 1'b1, 1'b1));
        // 2..3 clocks of synchronizer latency before T0, then the push latency
        n_cmp++; if (!seen || cnt < PUSH_LAT + 2 || cnt > PUSH_LAT + 3) begin
            n_fail++; $display("FAIL e1_latency got %0d exp %0d..%0d", cnt, PUSH_LAT + 2, PUSH_LAT + 3);
        end
        got = {frame_error, parity_error, d_out};
        n_cmp++; if (got !== exp_q[0]) begin n_fail++; $display("FAIL e1_head got %h exp %h", got, exp_q[0]); end
        pulse_rdn();
        model_pop();
        n_cmp++; if (r_ready !== 1'b0) begin n_fail++; $display("FAIL e1_pop_ready got %b exp 0", r_ready); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        logic       p;
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < DEPTH; k++) begin
                d = 8'($urandom_range(0, 255));
                p = 1'($urandom_range(0, 1));
                if (r == 0 && k == 0) begin d = 8'h55; p = 1'b1; end
                if (r == 0 && k == 1) begin d = 8'h55; p = 1'b0; end
                send_frame(d, p, 1'b1);
                model_push(frame_entry(d, p, 1'b1));
            end
            wait_clks(5);
            for (int k = 0; k < DEPTH; k++) begin
                got = {frame_error, parity_error, d_out};
                n_cmp++; if (r_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready r%0d k%0d got %b exp 1", r, k, r_ready); end
                n_cmp++; if (got !== exp_q[0]) begin n_fail++; $display("FAIL b2b_head r%0d k%0d got %h exp %h", r, k, got, exp_q[0]); end
                pulse_rdn();
                model_pop();
            end
            n_cmp++; if (r_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_empty r%0d got %b exp 0", r, r_ready); end
        end
    endtask

    task automatic test_break();
        logic [7:0] d;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(1'b0);
`ifdef UART_RX_PARITY_EN
        send_bit(1'b0);
`endif
        for (int i = 0; i < 41; i++) send_bit(1'b0);
        model_push(frame_entry(8'h00, 1'b0, 1'b0));
        rxd = 1'b1;
        wait_clks(32);
        got = {frame_error, parity_error, d_out};
        n_cmp++; if (r_ready !== 1'b1) begin n_fail++; $display("FAIL break_ready got %b exp 1", r_ready); end
        n_cmp++; if (got !== exp_q[0]) begin n_fail++; $display("FAIL break_head got %h exp %h", got, exp_q[0]); end
        pulse_rdn();
        model_pop();
        n_cmp++; if (r_ready !== 1'b0) begin n_fail++; $display("FAIL break_single got %b exp 0", r_ready); end
        d = 8'($urandom_range(0, 255));
        send_frame(d, good_pbit(d), 1'b1);
        model_push(frame_entry(d, good_pbit(d), 1'b1));
        wait_clks(2);
        got = {frame_error, parity_error, d_out};
        n_cmp++; if (got !== exp_q[0]) begin n_fail++; $display("FAIL after_break_head got %h exp %h", got, exp_q[0]); end
        pulse_rdn();
        model_pop();
    endtask

    task automatic test_glitch();
        rxd = 1'b0;
        wait_clks(4);
        rxd = 1'b1;
        wait_clks(30);
        n_cmp++; if (fsm_state !== IDLE) begin n_fail++; $display("FAIL glitch_state got %0d exp %0d", fsm_state, IDLE); end
        wait_clks(200);
        n_cmp++; if (r_ready !== 1'b0) begin n_fail++; $display("FAIL glitch_no_entry got %b exp 0", r_ready); end
        // pop while empty is ignored
        pulse_rdn();
        model_pop();
        n_cmp++; if (r_ready !== 1'b0 || overrun !== exp_overrun) begin
            n_fail++; $display("FAIL empty_pop got ready=%b ovr=%b exp ready=0 ovr=%b", r_ready, overrun, exp_overrun);
        end
    endtask

    task automatic test_overrun();
        logic [7:0] d;
        for (int v = 1; v <= DEPTH + 1; v++) begin
            d = 8'(v);
            send_frame(d, good_pbit(d), 1'b1);
            model_push(frame_entry(d, good_pbit(d), 1'b1));
        end
        wait_clks(5);
        got = {frame_error, parity_error, d_out};
        n_cmp++; if (overrun !== exp_overrun) begin n_fail++; $display("FAIL ovr_set got %b exp %b", overrun, exp_overrun); end
        n_cmp++; if (got !== exp_q[0]) begin n_fail++; $display("FAIL ovr_head got %h exp %h", got, exp_q[0]); end
        pulse_rdn();
        model_pop();
        n_cmp++; if (overrun !== exp_overrun) begin n_fail++; $display("FAIL ovr_clear got %b exp %b", overrun, exp_overrun); end
        while (exp_q.size() > 0) begin
            got = {frame_error, parity_error, d_out};
            n_cmp++; if (r_ready !== 1'b1 || got !== exp_q[0]) begin
                n_fail++; $display("FAIL ovr_drain got ready=%b head=%h exp ready=1 head=%h", r_ready, got, exp_q[0]);
            end
            pulse_rdn();
            model_pop();
        end
        n_cmp++; if (r_ready !== 1'b0) begin n_fail++; $display("FAIL ovr_empty got %b exp 0", r_ready); end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #5_000_000;
        n_fail++;
        $display("FAIL watchdog got timeout exp completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "timeout");
    end

    // ---------------- sequence and report ----------------
    initial begin
        clrn = 1'b0;
        rxd  = 1'b1;
        rdn  = 1'b1;
        exp_overrun = 1'b0;
        @(posedge clk16x);
        #1;
        test_reset();
        test_first_frame();
        test_back_to_back();
        test_break();
        test_glitch();
        test_overrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
